// File: rtl/elevator_group_dispatcher.sv
// Hall-call scheduler for a two-car group: latches landing calls, round-robin picks one, assigns it to the cheaper car.
// Latency: call captured at E0, offer valid after E3 (IDLE, SELECT, COST), pending clears on the handshake edge.
// Backpressure: hall calls are never stalled; an offer holds until the target car is ready or the target faults.
module elevator_group_dispatcher #(
    parameter int FLOORS = 8,
    parameter int FW     = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hall_call_valid,
    input  logic [FW-1:0]     hall_call_floor,
    input  logic [FW-1:0]     car0_floor,
    input  logic              car0_up,
    input  logic              car0_down,
    input  logic              car0_fault,
    input  logic              car0_assign_ready,
    input  logic [FW-1:0]     car1_floor,
    input  logic              car1_up,
    input  logic              car1_down,
    input  logic              car1_fault,
    input  logic              car1_assign_ready,
    output logic              car0_assign_valid,
    output logic [FW-1:0]     car0_assign_floor,
    output logic              car1_assign_valid,
    output logic [FW-1:0]     car1_assign_floor,
    output logic [FLOORS-1:0] pending,
    output logic              busy,
    output logic              no_car_avail,
    output logic [7:0]        dispatch_count
);
    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_COST, S_ISSUE} state_t;

    localparam logic [FW:0]   LP_FLOORS = (FW+1)'(FLOORS);
    localparam logic [FW-1:0] LP_LAST   = FW'(FLOORS-1);
    localparam logic [4:0]    LP_NOCAR  = 5'd31;

    state_t              r_state, w_state_nxt;
    logic [FLOORS-1:0]   r_pending;
    logic [FW-1:0]       r_rr_ptr;
    logic [FW-1:0]       r_sel;
    logic                r_target;
    logic                r_tie_flag;
    logic                r_no_car_avail;
    logic [7:0]          r_dispatch_count;

    logic [FW:0]         w_scan_idx;
    logic [FW-1:0]       w_scan_sel;
    logic                w_found;
    logic [4:0]          w_cost0, w_cost1;
    logic                w_both_out, w_tie, w_pick;
    logic                w_tgt_fault, w_hs;
    logic [FLOORS-1:0]   w_set, w_clr;
    logic [FW-1:0]       w_sel_inc;

    function automatic logic [4:0] f_cost(input logic [FW-1:0] fl, input logic up, input logic dn,
                                          input logic flt, input logic [FW-1:0] s);
        logic [FW-1:0] d;
        logic          away;
        if (flt) return LP_NOCAR;
        d    = (fl > s) ? fl - s : s - fl;
        away = (up && (s < fl)) || (dn && (s > fl));
        return 5'(d) + (away ? 5'd8 : 5'd0);
    endfunction

    // First pending floor at or after the round-robin pointer, wrapping past the top landing.
    always_comb begin
        w_scan_idx = '0;
        w_scan_sel = r_rr_ptr;
        w_found    = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            w_scan_idx = {1'b0, r_rr_ptr} + (FW+1)'(i);
            if (w_scan_idx >= LP_FLOORS) w_scan_idx = w_scan_idx - LP_FLOORS;
            if (!w_found && r_pending[w_scan_idx[FW-1:0]]) begin
                w_found    = 1'b1;
                w_scan_sel = w_scan_idx[FW-1:0];
            end
        end
    end

    assign w_cost0    = f_cost(car0_floor, car0_up, car0_down, car0_fault, r_sel);
    assign w_cost1    = f_cost(car1_floor, car1_up, car1_down, car1_fault, r_sel);
    assign w_both_out = (w_cost0 == LP_NOCAR) && (w_cost1 == LP_NOCAR);
    assign w_tie      = (w_cost0 == w_cost1);
    assign w_pick     = w_tie ? r_tie_flag : (w_cost1 < w_cost0);

    // Valid is gated by the target's fault so a faulting car sees the offer withdrawn immediately.
    assign w_tgt_fault       = r_target ? car1_fault : car0_fault;
    assign car0_assign_valid = (r_state == S_ISSUE) && !r_target && !car0_fault;
    assign car1_assign_valid = (r_state == S_ISSUE) &&  r_target && !car1_fault;
    assign car0_assign_floor = r_sel;
    assign car1_assign_floor = r_sel;
    assign w_hs = (car0_assign_valid && car0_assign_ready) || (car1_assign_valid && car1_assign_ready);

    assign w_set     = {{(FLOORS-1){1'b0}}, hall_call_valid} << hall_call_floor;
    assign w_clr     = {{(FLOORS-1){1'b0}}, w_hs} << r_sel;
    assign w_sel_inc = (r_sel == LP_LAST) ? '0 : r_sel + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (|r_pending) w_state_nxt = S_SELECT;
            S_SELECT: w_state_nxt = S_COST;
            S_COST:   w_state_nxt = w_both_out ? S_IDLE : S_ISSUE;
            S_ISSUE:  if (w_tgt_fault || w_hs) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_pending        <= '0;
            r_rr_ptr         <= '0;
            r_sel            <= '0;
            r_target         <= 1'b0;
            r_tie_flag       <= 1'b0;
            r_no_car_avail   <= 1'b0;
            r_dispatch_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_pending | w_set) & ~w_clr;
            if (r_state == S_SELECT) r_sel <= w_scan_sel;
            if (r_state == S_COST) begin
                r_no_car_avail <= w_both_out;
                if (!w_both_out) begin
                    r_target <= w_pick;
                    if (w_tie) r_tie_flag <= ~r_tie_flag;
                end
            end
            if (w_hs) begin
                r_rr_ptr         <= w_sel_inc;
                r_dispatch_count <= r_dispatch_count + 8'd1;
            end
        end
    end

    assign pending        = r_pending;
    assign busy           = (r_state != S_IDLE);
    assign no_car_avail   = r_no_car_avail;
    assign dispatch_count = r_dispatch_count;
endmodule

// File: tb/tb_elevator_group_dispatcher.sv
// Bench for elevator_group_dispatcher: scenario tasks with inline checks plus an assignment scoreboard.
module tb_elevator_group_dispatcher;
    logic       clock = 1'b0;
    logic       reset;
    logic       hall_call_valid;
    logic [2:0] hall_call_floor;
    logic [2:0] car0_floor, car1_floor;
    logic       car0_up, car0_down, car0_fault, car0_assign_ready;
    logic       car1_up, car1_down, car1_fault, car1_assign_ready;
    logic       car0_assign_valid, car1_assign_valid;
    logic [2:0] car0_assign_floor, car1_assign_floor;
    logic [7:0] pending;
    logic       busy, no_car_avail;
    logic [7:0] dispatch_count;

    typedef struct packed {logic car; logic [2:0] floor;} exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    elevator_group_dispatcher #(.FLOORS(8), .FW(3)) dut (
        .clock(clock), .reset(reset),
        .hall_call_valid(hall_call_valid), .hall_call_floor(hall_call_floor),
        .car0_floor(car0_floor), .car0_up(car0_up), .car0_down(car0_down),
        .car0_fault(car0_fault), .car0_assign_ready(car0_assign_ready),
        .car1_floor(car1_floor), .car1_up(car1_up), .car1_down(car1_down),
        .car1_fault(car1_fault), .car1_assign_ready(car1_assign_ready),
        .car0_assign_valid(car0_assign_valid), .car0_assign_floor(car0_assign_floor),
        .car1_assign_valid(car1_assign_valid), .car1_assign_floor(car1_assign_floor),
        .pending(pending), .busy(busy), .no_car_avail(no_car_avail),
        .dispatch_count(dispatch_count)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every accepted offer must match the oldest expected assignment.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            n_cmp++;
            if (car0_assign_valid && car1_assign_valid) begin
                n_err++;
                $display("FAIL one_hot_valid: both valids high, required at most one");
            end
            if ((car0_assign_valid && car0_assign_ready) || (car1_assign_valid && car1_assign_ready)) begin
                exp_t e;
                exp_t g;
                g.car   = car1_assign_valid && car1_assign_ready;
                g.floor = g.car ? car1_assign_floor : car0_assign_floor;
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: car%0d floor %0d accepted, none expected", g.car, g.floor);
                end else begin
                    e = q.pop_front();
                    if (g !== e) begin
                        n_err++;
                        $display("FAIL sb_assign: got car%0d floor %0d, required car%0d floor %0d",
                                 g.car, g.floor, e.car, e.floor);
                    end
                end
            end
        end
    end

    task automatic set_defaults;
        hall_call_valid = 0; hall_call_floor = 0;
        car0_floor = 0; car0_up = 0; car0_down = 0; car0_fault = 0; car0_assign_ready = 1;
        car1_floor = 0; car1_up = 0; car1_down = 0; car1_fault = 0; car1_assign_ready = 1;
    endtask

    task automatic do_reset;
        reset = 0;
        set_defaults();
        q.delete();
        repeat (2) @(negedge clock);
        reset = 1;
        @(posedge clock); #1;
    endtask

    // Called at drive phase; returns at drive phase after the capture edge.
    task automatic call(input logic [2:0] f);
        hall_call_valid = 1; hall_call_floor = f;
        @(posedge clock); #1;
        hall_call_valid = 0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (pending == 8'h00 && !busy) begin
                cyc = i;
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        logic [29:0] outs;
        int bad = 0;
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            {hall_call_valid, hall_call_floor, car0_floor, car0_up, car0_down, car0_fault,
             car0_assign_ready, car1_floor, car1_up, car1_down, car1_fault, car1_assign_ready} = 20'($urandom);
            @(negedge clock);
            outs = {car0_assign_valid, car1_assign_valid, car0_assign_floor, car1_assign_floor,
                    pending, busy, no_car_avail, dispatch_count};
            if (outs !== 30'h0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_outputs: %0d cycles with nonzero outputs, required 0", bad);
        end
        set_defaults();
        car1_floor = 5;
        reset = 1;
        @(posedge clock); #1;
        q.push_back('{car: 1'b1, floor: 3'd6});
        call(3'd6);
        @(negedge clock);
        n_cmp++;
        if (pending !== 8'h40 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL capture: pending %h busy %b, required 40 0", pending, busy);
        end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            @(negedge clock);
            n_cmp++;
            if (car1_assign_valid !== (k == 3) || car0_assign_valid !== 1'b0) begin
                n_err++;
                $display("FAIL latency_e%0d: v0 %b v1 %b, required 0 %b", k,
                         car0_assign_valid, car1_assign_valid, (k == 3));
            end
            if (k == 3) begin
                n_cmp++;
                if (car1_assign_floor !== 3'd6) begin
                    n_err++;
                    $display("FAIL issue_floor: got %0d required 6", car1_assign_floor);
                end
            end
        end
        n_cmp++;
        if (pending !== 8'h00 || dispatch_count !== 8'd1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL first_done: pending %h count %0d busy %b, required 00 1 0",
                     pending, dispatch_count, busy);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_direction;
        int c;
        do_reset();
        car0_floor = 2; car0_up = 1; car1_floor = 6;
        q.push_back('{car: 1'b1, floor: 3'd1});
        call(3'd1);
        wait_idle(c);
        n_cmp++;
        if (c < 0 || dispatch_count !== 8'd1) begin
            n_err++;
            $display("FAIL direction_done: wait %0d count %0d, required >=0 1", c, dispatch_count);
        end
    endtask

    task automatic test_round_robin_tie;
        int c;
        do_reset();
        car1_floor = 7;
        q.push_back('{car: 1'b0, floor: 3'd3});
        call(3'd3);
        wait_idle(c);
        car0_floor = 4; car1_floor = 4;
        q.push_back('{car: 1'b0, floor: 3'd5});
        q.push_back('{car: 1'b1, floor: 3'd3});
        call(3'd3);
        call(3'd5);
        wait_idle(c);
        n_cmp++;
        if (c < 0 || dispatch_count !== 8'd3) begin
            n_err++;
            $display("FAIL rr_done: wait %0d count %0d, required >=0 3", c, dispatch_count);
        end
    endtask

    task automatic test_fault;
        int c;
        bit seen = 0;
        do_reset();
        car0_fault = 1; car1_fault = 1;
        call(3'd2);
        repeat (6) @(negedge clock);
        n_cmp++;
        if (no_car_avail !== 1'b1 || pending !== 8'h04 || dispatch_count !== 8'd0) begin
            n_err++;
            $display("FAIL both_faulted: nca %b pending %h count %0d, required 1 04 0",
                     no_car_avail, pending, dispatch_count);
        end
        @(posedge clock); #1;
        car0_fault = 0;
        q.push_back('{car: 1'b0, floor: 3'd2});
        wait_idle(c);
        n_cmp++;
        if (c < 0 || no_car_avail !== 1'b0 || dispatch_count !== 8'd1) begin
            n_err++;
            $display("FAIL fault_recover: wait %0d nca %b count %0d, required >=0 0 1",
                     c, no_car_avail, dispatch_count);
        end
        car0_assign_ready = 0;
        call(3'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (car0_assign_valid) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL fault_offer: valid0 never rose, required 1");
        end
        @(posedge clock); #1;
        car0_fault = 1;
        @(negedge clock);
        n_cmp++;
        if (car0_assign_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fault_withdraw: valid0 %b, required 0", car0_assign_valid);
        end
        repeat (5) @(negedge clock);
        n_cmp++;
        if (pending !== 8'h04 || dispatch_count !== 8'd1 || no_car_avail !== 1'b1) begin
            n_err++;
            $display("FAIL fault_keep: pending %h count %0d nca %b, required 04 1 1",
                     pending, dispatch_count, no_car_avail);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back;
        int bad = 0;
        bit seen = 0;
        do_reset();
        car0_floor = 3; car1_floor = 7; car1_fault = 1; car0_assign_ready = 0;
        q.push_back('{car: 1'b0, floor: 3'd3});
        call(3'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (car0_assign_valid) begin
                seen = 1;
                break;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (car0_assign_valid !== 1'b1 || car0_assign_floor !== 3'd3) bad++;
        end
        n_cmp++;
        if (!seen || bad != 0) begin
            n_err++;
            $display("FAIL hold_stable: seen %0d unstable %0d, required 1 0", seen, bad);
        end
        @(posedge clock); #1;
        car0_assign_ready = 1;
        call(3'd3);
        @(negedge clock);
        n_cmp++;
        if (pending !== 8'h00 || dispatch_count !== 8'd1) begin
            n_err++;
            $display("FAIL merge_clear: pending %h count %0d, required 00 1", pending, dispatch_count);
        end
        repeat (6) @(negedge clock);
        n_cmp++;
        if (dispatch_count !== 8'd1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL merge_once: count %0d busy %b, required 1 0", dispatch_count, busy);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        set_defaults();
        test_reset();
        test_direction();
        test_round_robin_tie();
        test_fault();
        test_back_to_back();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d expected assignments never seen, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/elevator_group_dispatcher.md
# elevator_group_dispatcher

Hall-call scheduler for a two-car group built from `elevator_design` cars (8 floors). It latches landing hall calls into a pending bitmap and picks one pending floor at a time with a round-robin pointer. It scores both cars by distance and direction, then hands the floor to the cheaper car over a valid/ready assignment handshake. It sits between the landing call panels and the per-car controllers' `req_floor` inputs.

## Interface
- `FLOORS`, 8, number of landings (bitmap width)
- `FW`, 3, floor index width, clog2(FLOORS)
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `hall_call_valid`  in  1  hall call strobe, one call per cycle
- `hall_call_floor`  in  FW  landing of the call
- `carN_floor` (N=0,1)  in  FW  car current_floor
- `carN_up`, `carN_down`  in  1  car moving direction
- `carN_fault`  in  1  car emergency_stop or over_weight; car unavailable
- `carN_assign_ready`  in  1  car accepts an assignment
- `carN_assign_valid`  out  1  assignment offered to car N
- `carN_assign_floor`  out  FW  floor being assigned
- `pending`  out  FLOORS  unassigned hall calls
- `busy`  out  1  FSM not in IDLE
- `no_car_avail`  out  1  last COST found both cars faulted
- `dispatch_count`  out  8  completed assignments, wraps 255→0

## Operation
- Hall call: `hall_call_valid` sets `pending[hall_call_floor]` on the clock edge. A duplicate call to a set bit is merged.
- FSM states: IDLE, SELECT, COST, ISSUE.
- IDLE: if `pending`≠0, go to SELECT. Otherwise stay.
- SELECT: latch `sel` = first set bit scanning from `rr_ptr` upward, wrapping FLOORS-1→0. Go to COST.
- COST: sample the car inputs. Compute 5-bit costN:
  - costN = |carN_floor − sel| (0..7), plus 8 if the car is moving away (up with sel<floor, or down with sel>floor).
  - costN = 31 if `carN_fault`.
- COST outcome:
  - Both costs 31: set `no_car_avail`=1, return to IDLE; the bit stays pending.
  - Otherwise latch target = the lower-cost car and go to ISSUE.
  - Equal costs: the target alternates using a `tie_flag` toggle. The first tie goes to car0.
  - A non-31 COST clears `no_car_avail`.
- ISSUE: drive `target_assign_valid`=1 and `target_assign_floor`=sel. Hold both stable until ready.
  - On valid&&ready: clear `pending[sel]`, set `rr_ptr`=(sel+1) mod FLOORS, increment `dispatch_count`, go to IDLE.
- Fault while in ISSUE: if the target car's `carN_fault` rises, drop valid and go to IDLE; the bit stays pending. This is the only allowed withdrawal of valid.
- Only one `carN_assign_valid` may be high at any time.

## Timing
- Reset (async assert, sync release): state=IDLE, `pending`=0, `rr_ptr`=0, `tie_flag`=0, all valids 0, assign floors 0, `busy`=0, `no_car_avail`=0, `dispatch_count`=0.
- Latency: call captured at edge E0; IDLE→SELECT at E1; SELECT→COST at E2; COST→ISSUE at E3. Valid is high after E3. With ready tied high, the pending bit clears at E4.
- Back-to-back dispatch: 4 cycles per call minimum. IDLE is always visited for one cycle between calls.
- Simultaneous set and clear of the same bit (new call arriving on the completing handshake edge): clear wins, and the call is merged into the assignment.
- Hall calls are accepted in every state, including during reset release; there is no backpressure.
- `reset` low mid-ISSUE: valid drops asynchronously and pending is lost.
- `carN_*` inputs are used only in COST. Changes in other states have no effect, except `carN_fault` during ISSUE.

## Test plan
- Reset: hold `reset`=0 with random inputs → all outputs 0. Release, call floor 6, car0 at 0 idle, car1 at 5 idle, readies=1 → car1 valid with floor 6 three cycles after capture; `pending`=0 next edge; count=1.
- Direction penalty: car0 at 2 moving up, car1 at 6 idle, call floor 1 → cost0=9, cost1=5, so car1 is assigned.
- Round-robin and tie: calls 3 and 5 together, `rr_ptr`=4, both cars at 4 idle → floor 5 is dispatched first to car0, then floor 3 to car1 via the tie toggle.
- Fault handling: both faulted, call 2 → `no_car_avail`=1, pending stays 0x04. Clear car0 fault → car0 assigned floor 2. Then raise car0 fault while in ISSUE with ready=0 → valid drops and the bit stays pending.
- Handshake hold: ready=0 for 5 cycles → valid and floor stay stable. The duplicate call lands on the ready edge → bit ends cleared and count increments once.
